// File: rtl/mem0_pkg.sv
// mem0_pkg: memory-op encodings, packet layout and pipeline register type
// shared by the mem0 stage and its packet queue.
package mem0_pkg;
   typedef enum logic [2:0] {
      DOPC_NOP, DOPC_LW, DOPC_LH, DOPC_LB, DOPC_SW, DOPC_SH, DOPC_SB, DOPC_RSV
   } dopc_e;
   localparam int OPR_W = 32;
   localparam int PE_W = 3;
   localparam int NODE_W = 16;
   localparam int GEN_W = 12;
   localparam int ADDR_W = 14;
   localparam int PKT_OPR_LSB = 0;
   localparam int PKT_GEN_LSB = PKT_OPR_LSB + OPR_W;
   localparam int PKT_NODE_LSB = PKT_GEN_LSB + GEN_W;
   localparam int PKT_PE_LSB = PKT_NODE_LSB + NODE_W;
   localparam int PKT_W = PKT_PE_LSB + PE_W;
   typedef struct packed {
      logic [OPR_W-1:0]  opr0;
      logic [OPR_W-1:0]  opr1;
      logic [ADDR_W-1:0] addr;
      logic              wen;
      dopc_e             dopc;
      logic              pe_out;
      logic [PE_W-1:0]   pe_num;
      logic              f_mem_w;
      logic              next_lr;
      logic              next_uni_opr;
      logic [NODE_W-1:0] next_node;
      logic [GEN_W-1:0]  gen;
   } pipe_t;
   function automatic logic [PKT_W-1:0] pack_pkt(input pipe_t p);
      logic [PKT_W-1:0] k;
      k = '0;
      k[PKT_PE_LSB +: PE_W] = p.pe_num;
      k[PKT_NODE_LSB +: NODE_W] = p.next_node;
      k[PKT_GEN_LSB +: GEN_W] = p.gen;
      k[PKT_OPR_LSB +: OPR_W] = p.opr0;
      return k;
   endfunction
   function automatic logic is_load(input dopc_e d);
      return d inside {DOPC_LW, DOPC_LH, DOPC_LB};
   endfunction
endpackage

// File: rtl/mem0_pkt_fifo.sv
// pkt_fifo: PE-output packet queue; exposes next-cycle occupancy so the
// parent can register its stall flag, and a sticky overflow flag.
module pkt_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 63
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               din,
   input  logic                       ready,
   output logic                       valid,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH):0]     count_nxt,
   output logic                       ovf
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] count;
   logic full, empty, pop, wr;
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign pop = !empty & ready;
   // a push into a full queue still lands when the head leaves the same edge
   assign wr = push & (!full | pop);
   assign count_nxt = count + CW'(wr) - CW'(pop);
   assign valid = !empty;
   assign dout = empty ? '0 : mem[rp];
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
         ovf <= 1'b0;
      end else begin
         if (wr) wp <= wp + AW'(1);
         if (pop) rp <= rp + AW'(1);
         count <= count_nxt;
         ovf <= ovf | (push & full & !pop);
      end
   always_ff @(posedge clk)
      if (wr) mem[wp] <= din;
endmodule

// File: rtl/mem0.sv
// mem0: memory stage -- drives the synchronous data SRAM from its pipeline
// register, forwards operands to the next stage and queues PE-output packets.
module mem0
   import mem0_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int STALL_TH = FIFO_DEPTH - 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] opr0_i_mem0,
   input  logic [31:0] opr1_i_mem0,
   input  logic [13:0] dm_addr_i_mem0,
   input  logic        mem_wen_i_mem0,
   input  logic [2:0]  dm_dopc_i_mem0,
   input  logic        pe_out_i_mem0,
   input  logic [2:0]  pe_num_i_mem0,
   input  logic        f_mem_w_i_mem0,
   input  logic        next_lr_i_mem0,
   input  logic        next_uni_opr_i_mem0,
   input  logic [15:0] next_node_i_mem0,
   input  logic [11:0] gen_i_mem0,
   output logic        dm_en_o_mem0,
   output logic        dm_we_o_mem0,
   output logic [3:0]  dm_be_o_mem0,
   output logic [11:0] dm_waddr_o_mem0,
   output logic [31:0] dm_wdata_o_mem0,
   output logic [31:0] opr0_o_mem0,
   output logic [2:0]  dm_dopc_o_mem0,
   output logic [1:0]  byte_off_o_mem0,
   output logic        f_mem_w_o_mem0,
   output logic        next_lr_o_mem0,
   output logic        next_uni_opr_o_mem0,
   output logic [15:0] next_node_o_mem0,
   output logic [11:0] gen_o_mem0,
   output logic        pkt_valid_o_mem0,
   input  logic        pkt_ready_i_mem0,
   output logic [62:0] pkt_data_o_mem0,
   output logic        stall_o_mem0,
   output logic        ovf_o_mem0
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   pipe_t pr, nx;
   logic stall, push, ld, sw, sh, sb, st;
   logic [CW-1:0] cnt_nxt;
   assign nx = '{
      opr0: opr0_i_mem0, opr1: opr1_i_mem0, addr: dm_addr_i_mem0,
      wen: mem_wen_i_mem0, dopc: dopc_e'(dm_dopc_i_mem0), pe_out: pe_out_i_mem0,
      pe_num: pe_num_i_mem0, f_mem_w: f_mem_w_i_mem0, next_lr: next_lr_i_mem0,
      next_uni_opr: next_uni_opr_i_mem0, next_node: next_node_i_mem0, gen: gen_i_mem0
   };
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         pr <= '0;
         stall <= 1'b0;
      end else begin
         if (!stall) pr <= nx;
         stall <= int'(cnt_nxt) >= STALL_TH;
      end
   // misaligned word/half stores are dropped rather than split
   assign ld = !stall & is_load(pr.dopc);
   assign sw = !stall & pr.wen & pr.dopc == DOPC_SW & pr.addr[1:0] == 2'b00;
   assign sh = !stall & pr.wen & pr.dopc == DOPC_SH & !pr.addr[0];
   assign sb = !stall & pr.wen & pr.dopc == DOPC_SB;
   assign st = sw | sh | sb;
   assign dm_en_o_mem0 = ld | st;
   assign dm_we_o_mem0 = st;
   assign dm_be_o_mem0 = (ld | sw) ? 4'b1111 :
                         sh ? (pr.addr[1] ? 4'b1100 : 4'b0011) :
                         sb ? 4'b0001 << pr.addr[1:0] : 4'b0000;
   assign dm_waddr_o_mem0 = pr.addr[13:2];
   assign dm_wdata_o_mem0 = pr.dopc == DOPC_SH ? {2{pr.opr1[15:0]}} :
                            pr.dopc == DOPC_SB ? {4{pr.opr1[7:0]}} : pr.opr1;
   assign opr0_o_mem0 = pr.opr0;
   assign dm_dopc_o_mem0 = pr.dopc;
   assign byte_off_o_mem0 = pr.addr[1:0];
   assign f_mem_w_o_mem0 = pr.f_mem_w;
   assign next_lr_o_mem0 = pr.next_lr;
   assign next_uni_opr_o_mem0 = pr.next_uni_opr;
   assign next_node_o_mem0 = pr.next_node;
   assign gen_o_mem0 = pr.gen;
   assign stall_o_mem0 = stall;
   assign push = pr.pe_out & !stall;
   pkt_fifo #(.DEPTH(FIFO_DEPTH), .W(PKT_W)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(push),
      .din(pack_pkt(pr)),
      .ready(pkt_ready_i_mem0),
      .valid(pkt_valid_o_mem0),
      .dout(pkt_data_o_mem0),
      .count_nxt(cnt_nxt),
      .ovf(ovf_o_mem0)
   );
endmodule
